// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_*        : 3-bit operation select codes
//   state_e       : burst controller state (idle / burst in progress)
//   is_shift_mode : true for the modes that move bits (SHL..ASR)
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m != MODE_HOLD) && (m != MODE_LOAD) && (m != MODE_CLEAR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of a WIDTH-bit word.
//   q       : current register value
//   mode    : operation select (non-shift modes pass q through)
//   ser_in  : fill bit for SHL/SHR
//   next_q  : value after one step
//   out_bit : bit shifted or rotated out (0 for non-shift modes)
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_q  = {q[WIDTH-2:0], ser_in};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q  = {ser_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with single-cycle ops and a
// multi-cycle burst (one shift/rotate per enabled cycle).
//   clk, reset : clock, asynchronous active-high reset
//   enable     : qualifies every state change, including burst steps
//   mode       : operation select (see shift_reg_pkg)
//   data       : parallel load value
//   ser_in     : serial fill bit for SHL/SHR
//   start      : burst request, sampled when idle and enabled
//   amount     : burst step count, captured with start
//   q          : register contents
//   ser_out    : last bit shifted/rotated out
//   busy       : burst in progress
//   done       : one-cycle pulse when a start command completes
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int               CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  data,
    input  logic              ser_in,
    input  logic              start,
    input  logic [CNT_W-1:0]  amount,
    output logic [WIDTH-1:0]  q,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               ser_out_q, ser_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         burst_mode_q, burst_mode_d;

    logic [2:0]         step_mode;
    logic [WIDTH-1:0]   step_q;
    logic               step_bit;

    // A single step unit serves both paths: during a burst it follows the
    // captured mode so live mode changes cannot disturb the burst.
    assign step_mode = (state_q == ST_BUSY) ? burst_mode_q : mode;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q       (q_q),
        .mode    (step_mode),
        .ser_in  (ser_in),
        .next_q  (step_q),
        .out_bit (step_bit)
    );

    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        ser_out_d    = ser_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_d        = cnt_q;
        burst_mode_d = burst_mode_q;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && is_shift_mode(mode)) begin
                        if (amount == '0) begin
                            done_d = 1'b1;
                        end else begin
                            // Accepting edge only captures; first step is next edge.
                            burst_mode_d = mode;
                            cnt_d        = amount;
                            state_d      = ST_BUSY;
                            busy_d       = 1'b1;
                        end
                    end else begin
                        case (mode)
                            MODE_LOAD:  q_d = data;
                            MODE_CLEAR: q_d = '0;
                            MODE_HOLD:  q_d = q_q;
                            default: begin
                                q_d       = step_q;
                                ser_out_d = step_bit;
                            end
                        endcase
                        done_d = start;
                    end
                end
                ST_BUSY: begin
                    q_d       = step_q;
                    ser_out_d = step_bit;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            q_q          <= RESET_VAL;
            ser_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            burst_mode_q <= MODE_HOLD;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            ser_out_q    <= ser_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            burst_mode_q <= burst_mode_d;
        end
    end

    assign q       = q_q;
    assign ser_out = ser_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data;
    logic             ser_in;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .data    (data),
        .ser_in  (ser_in),
        .start   (start),
        .amount  (amount),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: register value as an integer 0..255, burst as a
    // remaining-step count.
    int m_q, m_ser, m_busy, m_done, m_cnt, m_mode;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q = 0; m_ser = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;
    endfunction

    function automatic void model_exec(input int op, input int d, input int si);
        int old;
        old = m_q;
        case (op)
            1: m_q = d;
            2: begin m_ser = old / 128; m_q = (old * 2) % 256 + si; end
            3: begin m_ser = old % 2;   m_q = old / 2 + si * 128; end
            4: begin m_ser = old / 128; m_q = (old * 2) % 256 + old / 128; end
            5: begin m_ser = old % 2;   m_q = old / 2 + (old % 2) * 128; end
            6: begin m_ser = old % 2;   m_q = old / 2 + (old / 128) * 128; end
            7: m_q = 0;
            default: ;
        endcase
    endfunction

    function automatic void model_edge();
        int nd;
        nd = 0;
        if (enable) begin
            if (m_busy == 0) begin
                if (start && mode >= 2 && mode <= 6) begin
                    if (amount == 0) nd = 1;
                    else begin
                        m_mode = int'(mode); m_cnt = int'(amount); m_busy = 1;
                    end
                end else begin
                    model_exec(int'(mode), int'(data), int'(ser_in));
                    if (start) nd = 1;
                end
            end else begin
                model_exec(m_mode, 0, int'(ser_in));
                m_cnt--;
                if (m_cnt == 0) begin m_busy = 0; nd = 1; end
            end
        end
        m_done = nd;
    endfunction

    task automatic tick();
        if (reset) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic en, input logic [2:0] md, input logic [7:0] d,
                          input logic si, input logic st, input logic [3:0] am);
        enable = en; mode = md; data = d; ser_in = si; start = st; amount = am;
    endtask

    typedef struct {
        logic [2:0] mode;
        logic [7:0] data;
        logic       si;
        logic [7:0] exp_q;
        logic       exp_ser;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{3'b001, 8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{3'b010, 8'h00, 1'b1, 8'h4B, 1'b1};
        vecs[2]  = '{3'b001, 8'hA5, 1'b0, 8'hA5, 1'b1};
        vecs[3]  = '{3'b011, 8'h00, 1'b0, 8'h52, 1'b1};
        vecs[4]  = '{3'b001, 8'h80, 1'b0, 8'h80, 1'b1};
        vecs[5]  = '{3'b110, 8'h00, 1'b0, 8'hC0, 1'b0};
        vecs[6]  = '{3'b100, 8'h00, 1'b0, 8'h81, 1'b1};
        vecs[7]  = '{3'b101, 8'h00, 1'b0, 8'hC0, 1'b1};
        vecs[8]  = '{3'b000, 8'hFF, 1'b0, 8'hC0, 1'b1};
        vecs[9]  = '{3'b111, 8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{3'b011, 8'h00, 1'b1, 8'h80, 1'b0};

        model_reset();
        set_in(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;

        // 1: reset with LOAD presented
        #2 reset = 1'b1;
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        tick();
        chk("reset_held_q", int'(q), 0);
        reset = 1'b0;
        tick();
        chk("load_a5", int'(q), 8'hA5);

        // 2: enable low holds everything
        set_in(1'b0, 3'b001, 8'h3C, 1'b0, 1'b0, 4'd0);
        repeat (5) tick();
        chk("en0_hold_q", int'(q), 8'hA5);
        enable = 1'b1;
        tick();
        chk("en1_load_3c", int'(q), 8'h3C);

        // 3: single-cycle ops table
        for (int i = 0; i < 11; i++) begin
            set_in(1'b1, vecs[i].mode, vecs[i].data, vecs[i].si, 1'b0, 4'd0);
            tick();
            chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
            chk($sformatf("vec%0d_ser", i), int'(ser_out), int'(vecs[i].exp_ser));
            chk($sformatf("vec%0d_done", i), int'(done), 0);
        end

        // 4: ROL burst of 3 from 0x81, inputs scrambled during the burst
        set_in(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 4'd0);
        tick();
        set_in(1'b1, 3'b100, 8'h00, 1'b0, 1'b1, 4'd3);
        tick();
        chk("rol_acc_busy", int'(busy), 1);
        chk("rol_acc_q", int'(q), 8'h81);
        chk("rol_acc_done", int'(done), 0);
        set_in(1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 4'd7);
        tick();
        chk("rol_s1_q", int'(q), 8'h03);
        chk("rol_s1_busy", int'(busy), 1);
        tick();
        chk("rol_s2_q", int'(q), 8'h06);
        chk("rol_s2_done", int'(done), 0);
        set_in(1'b1, 3'b111, 8'hFF, 1'b0, 1'b0, 4'd0);
        tick();
        chk("rol_s3_q", int'(q), 8'h0C);
        chk("rol_s3_busy", int'(busy), 0);
        chk("rol_s3_done", int'(done), 1);
        mode = 3'b000;
        tick();
        chk("rol_done_pulse", int'(done), 0);
        chk("rol_after_q", int'(q), 8'h0C);

        // 5: SHR burst of 2 with a one-cycle stall
        set_in(1'b1, 3'b001, 8'hF0, 1'b0, 1'b0, 4'd0);
        tick();
        set_in(1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 4'd2);
        tick();
        chk("shr_acc_busy", int'(busy), 1);
        start = 1'b0;
        tick();
        chk("shr_s1_q", int'(q), 8'h78);
        enable = 1'b0;
        tick();
        chk("shr_stall_q", int'(q), 8'h78);
        chk("shr_stall_busy", int'(busy), 1);
        chk("shr_stall_done", int'(done), 0);
        enable = 1'b1;
        tick();
        chk("shr_s2_q", int'(q), 8'h3C);
        chk("shr_s2_busy", int'(busy), 0);
        chk("shr_s2_done", int'(done), 1);

        // 5b: amount zero
        set_in(1'b1, 3'b001, 8'hF0, 1'b0, 1'b0, 4'd0);
        tick();
        set_in(1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 4'd0);
        tick();
        chk("amt0_q", int'(q), 8'hF0);
        chk("amt0_busy", int'(busy), 0);
        chk("amt0_done", int'(done), 1);
        set_in(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        chk("amt0_done_clr", int'(done), 0);

        // 6: async reset mid-burst, then a fresh burst
        set_in(1'b1, 3'b001, 8'h5A, 1'b0, 1'b0, 4'd0);
        tick();
        set_in(1'b1, 3'b100, 8'h00, 1'b0, 1'b1, 4'd5);
        tick();
        start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        model_reset();
        tick();
        reset = 1'b0;
        set_in(1'b1, 3'b001, 8'h03, 1'b0, 1'b0, 4'd0);
        tick();
        set_in(1'b1, 3'b101, 8'h00, 1'b0, 1'b1, 4'd2);
        tick();
        start = 1'b0;
        tick();
        chk("post_rst_s1", int'(q), 8'h81);
        tick();
        chk("post_rst_s2", int'(q), 8'hC0);
        chk("post_rst_done", int'(done), 1);

        // Random stimulus against the reference model
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(7) != 0), 3'($urandom_range(7)), 8'($urandom),
                   1'($urandom), ($urandom_range(3) == 0), 4'($urandom_range(15)));
            tick();
            chk("rnd_q", int'(q), m_q);
            chk("rnd_ser", int'(ser_out), m_ser);
            chk("rnd_busy", int'(busy), m_busy);
            chk("rnd_done", int'(done), m_done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
